// File: rtl/qcom_cmd_issuer.sv
// Command issuer: buffers {op, dt} commands in a small FIFO and plays them one at a
// time onto the QCOM req/ack command port, with a per-command handshake timeout.
module qcom_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TOUT_CYC   = 65535
) (
    input  logic        c_clk_i,
    input  logic        c_rst_ni,
    input  logic        push_i,
    input  logic [3:0]  push_op_i,
    input  logic [31:0] push_dt_i,
    output logic        full_o,
    input  logic        flush_i,
    output logic        cmd_req_o,
    input  logic        cmd_ack_i,
    input  logic        qcom_rdy_i,
    output logic [3:0]  cmd_op_o,
    output logic [31:0] cmd_dt_o,
    output logic        busy_o,
    output logic [15:0] done_cnt_o,
    input  logic        err_clr_i,
    output logic        err_tout_o,
    output logic        err_ovf_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WACK_LO = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [35:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   occ_reg;
    logic [3:0]         op_reg;
    logic [31:0]        dt_reg;
    logic [15:0]        tout_reg;
    logic [15:0]        done_reg;
    logic               tout_err_reg, ovf_err_reg;

    logic               full, empty, push_ok, ovf_evt;
    logic               issue, complete, tout_hit, tout_evt;
    logic [35:0]        head;

    assign full     = (occ_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (occ_reg == '0);
    // Full is judged on the pre-edge occupancy, and a flush swallows any push silently.
    assign push_ok  = push_i & ~full & ~flush_i;
    assign ovf_evt  = push_i &  full & ~flush_i;
    assign head     = mem[rd_ptr_reg];

    assign issue    = (state_reg == ST_IDLE) && !empty && qcom_rdy_i && !flush_i;
    assign complete = (state_reg == ST_WACK_LO) && !cmd_ack_i && qcom_rdy_i;
    assign tout_hit = (state_reg != ST_IDLE) && (tout_reg == 16'(TOUT_CYC - 1));
    // A handshake that completes on the very last allowed cycle is not a timeout.
    assign tout_evt = tout_hit && !complete;

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) state_reg <= ST_IDLE;
        else           state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (issue) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (tout_hit)       state_next = ST_IDLE;
                else if (cmd_ack_i) state_next = ST_WACK_LO;
            end
            ST_WACK_LO: begin
                if (complete || tout_hit) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_req_o = (state_reg == ST_REQ);
        busy_o    = (state_reg != ST_IDLE) || !empty;
    end

    always_ff @(posedge c_clk_i) begin
        if (push_ok) mem[wr_ptr_reg] <= {push_op_i, push_dt_i};
    end

    // The head leaves the queue as it is issued; flush only drops what is still queued.
    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (flush_i) begin
            occ_reg    <= '0;
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            occ_reg    <= occ_reg + CNT_W'(push_ok) - CNT_W'(issue);
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_ok);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(issue);
        end
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            op_reg       <= '0;
            dt_reg       <= '0;
            tout_reg     <= '0;
            done_reg     <= '0;
            tout_err_reg <= 1'b0;
            ovf_err_reg  <= 1'b0;
        end else begin
            if (issue) begin
                op_reg <= head[35:32];
                dt_reg <= head[31:0];
            end

            if (issue)                      tout_reg <= '0;
            else if (state_reg != ST_IDLE)  tout_reg <= tout_reg + 16'd1;

            if (complete) done_reg <= done_reg + 16'd1;

            if (tout_evt)       tout_err_reg <= 1'b1;
            else if (err_clr_i) tout_err_reg <= 1'b0;

            if (ovf_evt)        ovf_err_reg <= 1'b1;
            else if (err_clr_i) ovf_err_reg <= 1'b0;
        end
    end

    assign full_o     = full;
    assign cmd_op_o   = op_reg;
    assign cmd_dt_o   = dt_reg;
    assign done_cnt_o = done_reg;
    assign err_tout_o = tout_err_reg;
    assign err_ovf_o  = ovf_err_reg;

endmodule

// File: tb/tb_qcom_cmd_issuer.sv
// Bench for qcom_cmd_issuer: directed scenarios plus a random run, checked against a
// queue-based scoreboard and a simple QCOM responder model.
module tb_qcom_cmd_issuer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, push, flush, cmd_ack, qcom_rdy, err_clr;
    logic [3:0]  push_op;
    logic [31:0] push_dt;

    logic        full, cmd_req, busy, err_tout, err_ovf;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_dt;
    logic [15:0] done_cnt;

    logic        full_s, cmd_req_s, busy_s, err_tout_s, err_ovf_s;
    logic [3:0]  cmd_op_s;
    logic [31:0] cmd_dt_s;
    logic [15:0] done_cnt_s;

    qcom_cmd_issuer #(.FIFO_DEPTH(DEPTH), .TOUT_CYC(65535)) dut (
        .c_clk_i(clk), .c_rst_ni(rst_n), .push_i(push), .push_op_i(push_op),
        .push_dt_i(push_dt), .full_o(full), .flush_i(flush), .cmd_req_o(cmd_req),
        .cmd_ack_i(cmd_ack), .qcom_rdy_i(qcom_rdy), .cmd_op_o(cmd_op), .cmd_dt_o(cmd_dt),
        .busy_o(busy), .done_cnt_o(done_cnt), .err_clr_i(err_clr),
        .err_tout_o(err_tout), .err_ovf_o(err_ovf)
    );

    qcom_cmd_issuer #(.FIFO_DEPTH(DEPTH), .TOUT_CYC(16)) dut_s (
        .c_clk_i(clk), .c_rst_ni(rst_n), .push_i(push), .push_op_i(push_op),
        .push_dt_i(push_dt), .full_o(full_s), .flush_i(flush), .cmd_req_o(cmd_req_s),
        .cmd_ack_i(cmd_ack), .qcom_rdy_i(qcom_rdy), .cmd_op_o(cmd_op_s), .cmd_dt_o(cmd_dt_s),
        .busy_o(busy_s), .done_cnt_o(done_cnt_s), .err_clr_i(err_clr),
        .err_tout_o(err_tout_s), .err_ovf_o(err_ovf_s)
    );

    int          tests = 0;
    int          fails = 0;
    logic [35:0] exp_q[$];
    int          model_done, issued, qs, qcnt, ack_dly, hold_min, hold_max;
    bit          model_ovf, prev_req, qcom_en, release_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock: update the scoreboard for the edge, compare, then drive the QCOM responder.
    task automatic cycle();
        logic        rdy_applied;
        bit          ovf_evt;
        int          pre;
        logic [35:0] e;
        rdy_applied = qcom_rdy;
        step();
        pre     = exp_q.size();
        ovf_evt = 1'b0;
        if (flush) exp_q.delete();
        else if (push) begin
            if (pre < DEPTH) exp_q.push_back({push_op, push_dt});
            else             ovf_evt = 1'b1;
        end
        if (ovf_evt)      model_ovf = 1'b1;
        else if (err_clr) model_ovf = 1'b0;
        if (release_pending && rdy_applied) begin
            model_done++;
            release_pending = 1'b0;
        end
        if (cmd_req && !prev_req) begin
            if (exp_q.size() == 0) chk("unexpected_req", 32'(cmd_req), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("issue_op", 32'(cmd_op), 32'(e[35:32]));
                chk("issue_dt", cmd_dt, e[31:0]);
                issued++;
            end
        end
        prev_req = cmd_req;
        chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
        chk("err_ovf", 32'(err_ovf), 32'(model_ovf));
        chk("done_cnt", 32'(done_cnt), model_done & 32'hFFFF);
        chk("err_tout", 32'(err_tout), 32'd0);
        if (qs == 2) begin
            if (qcnt == 0) begin
                cmd_ack = 1'b0;
                release_pending = 1'b1;
                qs = 0;
            end else qcnt--;
        end else begin
            if (qs == 0 && qcom_en && cmd_req) begin
                qcnt = $urandom_range(ack_dly, 0);
                qs = 1;
            end
            if (qs == 1) begin
                if (qcnt == 0) begin
                    cmd_ack = 1'b1;
                    qcnt = $urandom_range(hold_max, hold_min);
                    qs = 2;
                end else qcnt--;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; push = 1'b0; flush = 1'b0; cmd_ack = 1'b0; err_clr = 1'b0;
        qcom_rdy = 1'b1; push_op = '0; push_dt = '0;
        #1;
        chk("rst_req", 32'(cmd_req), 32'd0);
        chk("rst_req_s", 32'(cmd_req_s), 32'd0);
        chk("rst_op", 32'(cmd_op), 32'd0);
        chk("rst_dt", cmd_dt, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        chk("rst_errs", {30'd0, err_tout, err_ovf}, 32'd0);
        step();
        step();
        exp_q.delete();
        model_done = 0; issued = 0; qs = 0; qcnt = 0;
        model_ovf = 1'b0; prev_req = 1'b0; release_pending = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic do_push(input logic [3:0] op, input logic [31:0] dt);
        push = 1'b1; push_op = op; push_dt = dt;
        cycle();
        push = 1'b0;
    endtask

    initial begin
        int          hi, held;
        logic [31:0] d1, d2, dsync;
        qcom_en = 1'b1; ack_dly = 0; hold_min = 4; hold_max = 4;

        // Single command, ack one cycle after req, released five cycles later.
        do_reset();
        push = 1'b1; push_op = 4'b0110; push_dt = 32'hDEADBEEF;
        cycle();
        push = 1'b0;
        chk("t1_req_edge_k", 32'(cmd_req), 32'd0);
        cycle();
        chk("t1_req_edge_k1", 32'(cmd_req), 32'd1);
        chk("t1_op", 32'(cmd_op), 32'h6);
        chk("t1_dt", cmd_dt, 32'hDEADBEEF);
        cycle();
        chk("t1_req_fall", 32'(cmd_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t1_op_hold", 32'(cmd_op), 32'h6);
            chk("t1_dt_hold", cmd_dt, 32'hDEADBEEF);
            chk("t1_busy_hold", 32'(busy), 32'd1);
        end
        cycle();
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Overflow with QCOM not ready, then in-order drain.
        do_reset();
        qcom_rdy = 1'b0; hold_min = 2; hold_max = 2;
        for (int i = 0; i < 5; i++) begin
            do_push(4'(i + 1), $urandom);
            if (i == 2) chk("t2_not_full3", 32'(full), 32'd0);
            if (i == 3) chk("t2_full4", 32'(full), 32'd1);
        end
        chk("t2_ovf", 32'(err_ovf), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("t2_ovf_clr", 32'(err_ovf), 32'd0);
        push = 1'b1; err_clr = 1'b1; push_op = 4'hF; push_dt = 32'h0BAD0BAD;
        cycle();
        push = 1'b0; err_clr = 1'b0;
        chk("t2_clr_vs_ovf", 32'(err_ovf), 32'd1);
        qcom_rdy = 1'b1;
        for (int n = 0; n < 200 && model_done < 4; n++) cycle();
        chk("t2_done", 32'(done_cnt), 32'd4);
        chk("t2_issued", 32'(issued), 32'd4);
        chk("t2_busy", 32'(busy), 32'd0);

        // Push together with flush on a full queue: flush wins, no overflow.
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        qcom_rdy = 1'b0;
        for (int i = 0; i < 4; i++) do_push(4'(i), $urandom);
        push = 1'b1; flush = 1'b1;
        cycle();
        push = 1'b0; flush = 1'b0;
        chk("t2_flush_full", 32'(full), 32'd0);
        chk("t2_flush_ovf", 32'(err_ovf), 32'd0);
        chk("t2_flush_busy", 32'(busy), 32'd0);
        qcom_rdy = 1'b1;
        repeat (10) cycle();
        chk("t2_flush_issued", 32'(issued), 32'd4);

        // Sync command with ack held for 1000 cycles.
        do_reset();
        hold_min = 999; hold_max = 999;
        dsync = $urandom;
        do_push(4'b1010, dsync);
        held = 0;
        for (int n = 0; n < 1100 && model_done == 0; n++) begin
            cycle();
            if (model_done == 0) begin
                chk("t3_op_hold", 32'(cmd_op), 32'hA);
                chk("t3_dt_hold", cmd_dt, dsync);
                held++;
            end
        end
        chk("t3_held", 32'(held), 32'd1001);
        chk("t3_done", 32'(done_cnt), 32'd1);

        // Timeout on the short-timeout instance, QCOM never acks.
        do_reset();
        qcom_en = 1'b0;
        d1 = $urandom; d2 = $urandom;
        do_push(4'h3, d1);
        do_push(4'h5, d2);
        hi = cmd_req_s ? 1 : 0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (cmd_req_s) hi++;
            else break;
        end
        chk("t4_req_cycles", 32'(hi), 32'd16);
        chk("t4_tout", 32'(err_tout_s), 32'd1);
        chk("t4_done", 32'(done_cnt_s), 32'd0);
        for (int n = 0; n < 10 && !cmd_req_s; n++) cycle();
        chk("t4_next_req", 32'(cmd_req_s), 32'd1);
        chk("t4_next_op", 32'(cmd_op_s), 32'h5);
        chk("t4_next_dt", cmd_dt_s, d2);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("t4_tout_clr", 32'(err_tout_s), 32'd0);

        // Flush while the first of three is in the ack-low phase.
        do_reset();
        qcom_en = 1'b1; ack_dly = 0; hold_min = 3; hold_max = 3;
        for (int i = 0; i < 3; i++) do_push(4'(i + 8), $urandom);
        for (int n = 0; n < 20 && !(cmd_ack && !cmd_req); n++) cycle();
        chk("t5_in_wack", 32'(cmd_ack && !cmd_req), 32'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (40) cycle();
        chk("t5_done", 32'(done_cnt), 32'd1);
        chk("t5_issued", 32'(issued), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);

        // Reset asserted while a request is outstanding.
        do_reset();
        qcom_en = 1'b0;
        do_push(4'h9, $urandom);
        do_push(4'h7, $urandom);
        chk("t6_req_before", 32'(cmd_req), 32'd1);
        do_reset();
        repeat (20) cycle();
        chk("t6_no_req", 32'(cmd_req), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        // Random traffic against the scoreboard, then drain.
        do_reset();
        qcom_en = 1'b1; ack_dly = 2; hold_min = 0; hold_max = 4;
        repeat (1500) begin
            push     = ($urandom_range(1, 0) == 1);
            push_op  = 4'($urandom);
            push_dt  = $urandom;
            flush    = ($urandom_range(49, 0) == 0);
            err_clr  = ($urandom_range(29, 0) == 0);
            qcom_rdy = ($urandom_range(3, 0) != 0);
            cycle();
        end
        push = 1'b0; flush = 1'b0; err_clr = 1'b0; qcom_rdy = 1'b1;
        repeat (100) cycle();
        chk("rnd_done_vs_issued", 32'(done_cnt), 32'(issued));
        chk("rnd_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
